// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: next-PC select encodings, bubble word, reset PC.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mips_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  // sll $0,$0,0 -- decode treats it as a harmless no-op
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Sign-extended word offset of a branch immediate, in bytes
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC target computation and 4-way select (seq, branch, jump, jr).
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is loaded.
import mips_pkg::*;

module next_pc_mux (
  input  logic [1:0]  pc_src,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] id_pc_plus4,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_idx,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);

  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_jr_target;

  // Targets are relative to the redirecting instruction, which sits in ID
  assign w_br_target = id_pc_plus4 + branch_offset(branch_imm);
  assign w_j_target  = {id_pc_plus4[31:28], jump_idx, 2'b00};
  assign w_jr_target = jr_target & ~32'h0000_0003;

  // Select the next PC; sequential is the fallback for every other code
  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PCSRC_BR: next_pc = w_br_target;
      PCSRC_J:  next_pc = w_j_target;
      PCSRC_JR: next_pc = w_jr_target;
      default:  next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC priority, IF/ID pipeline register.
// Latency: fetched word reaches ID one edge later; a redirect costs one bubble.
// Backpressure: stall holds PC and IF/ID; flush still bubbles IF/ID while stalled.
import mips_pkg::*;

module if_stage #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pc_src,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_idx,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  input  logic [31:0] instr_in,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc_plus4;
  logic        r_id_valid;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_redirect;
  logic [1:0]  w_sel_src;

  assign w_pc_plus4 = r_pc + 32'd4;

  // A bubble in ID carries no control, so it can never redirect fetch
  assign w_redirect = r_id_valid && (pc_src != PCSRC_SEQ);
  assign w_sel_src  = w_redirect ? pc_src : PCSRC_SEQ;

  next_pc_mux u_next_pc_mux (
    .pc_src      (w_sel_src),
    .pc_plus4    (w_pc_plus4),
    .id_pc_plus4 (r_id_pc_plus4),
    .branch_imm  (branch_imm),
    .jump_idx    (jump_idx),
    .jr_target   (jr_target),
    .next_pc     (w_next_pc)
  );

  // PC and IF/ID update: reset > stall > redirect > sequential
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_id_instr    <= NOP_INSTR;
      r_id_pc_plus4 <= 32'd0;
      r_id_valid    <= 1'b0;
    end else if (stall) begin
      if (flush) begin
        r_id_instr    <= NOP_INSTR;
        r_id_pc_plus4 <= 32'd0;
        r_id_valid    <= 1'b0;
      end
    end else begin
      r_pc <= w_next_pc;
      if (flush || w_redirect) begin
        // Squash the wrong-path word fetched this cycle
        r_id_instr    <= NOP_INSTR;
        r_id_pc_plus4 <= 32'd0;
        r_id_valid    <= 1'b0;
      end else begin
        r_id_instr    <= instr_in;
        r_id_pc_plus4 <= w_pc_plus4;
        r_id_valid    <= 1'b1;
      end
    end
  end

  assign pc          = r_pc;
  assign id_instr    = r_id_instr;
  assign id_pc_plus4 = r_id_pc_plus4;
  assign id_valid    = r_id_valid;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage with a behavioural fetch model.
// Latency: model advances once per clock edge alongside the DUT.
// Backpressure: stall/flush driven directly from the scenarios.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [1:0]  pc_src;
  logic [15:0] branch_imm;
  logic [25:0] jump_idx;
  logic [31:0] jr_target;
  logic [31:0] pc, instr_in, id_instr, id_pc_plus4;
  logic        id_valid;

  logic [31:0] mem [64];

  int errors = 0;
  int checks = 0;

  // Model state
  logic [31:0] m_pc, m_instr, m_pp4;
  logic        m_v;

  always #5 clk = ~clk;

  assign instr_in = mem[pc[7:2]];

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .pc_src(pc_src),
    .branch_imm(branch_imm), .jump_idx(jump_idx), .jr_target(jr_target),
    .pc(pc), .instr_in(instr_in), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4), .id_valid(id_valid)
  );

  // One clock edge; the model computes its next state from the rules
  task automatic tick();
    logic [31:0] n_pc, n_i, n_p, fetched;
    logic        n_v;
    fetched = mem[m_pc[7:2]];
    n_pc = m_pc; n_i = m_instr; n_p = m_pp4; n_v = m_v;
    if (reset) begin
      n_pc = 32'h0; n_i = 32'h0; n_p = 32'h0; n_v = 1'b0;
    end else if (stall) begin
      if (flush) begin n_i = 0; n_p = 0; n_v = 0; end
    end else if (m_v === 1'b1 && pc_src != 2'd0) begin
      case (pc_src)
        2'd1: n_pc = m_pp4 + 32'($signed(branch_imm)) * 32'd4;
        2'd2: n_pc = (m_pp4 & 32'hF000_0000) | (32'(jump_idx) * 32'd4);
        default: n_pc = jr_target - (jr_target % 32'd4);
      endcase
      n_i = 0; n_p = 0; n_v = 0;
    end else begin
      n_pc = m_pc + 32'd4;
      if (flush) begin n_i = 0; n_p = 0; n_v = 0; end
      else begin n_i = fetched; n_p = m_pc + 32'd4; n_v = 1; end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_i; m_pp4 = n_p; m_v = n_v;
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; flush = 0; pc_src = 2'd0;
    branch_imm = 16'h0; jump_idx = 26'h0; jr_target = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; stall = 1; pc_src = 2'b10;
    tick(); tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h exp=%h", id_instr, 32'h0); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
    checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pp4 got=%h exp=0", id_pc_plus4); end
    idle_inputs();
    tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL run_pc4 got=%h exp=4", pc); end
    tick();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL run_pc8 got=%h exp=8", pc); end
  endtask

  task automatic test_seq_fetch();
    do_reset();
    checks++; if (pc !== 32'h0 || id_valid !== 1'b0) begin errors++; $display("FAIL post_reset pc=%h valid=%b exp pc=0 valid=0", pc, id_valid); end
    tick();
    checks++; if (id_instr !== 32'h2008_0005) begin errors++; $display("FAIL seq_instr got=%h exp=20080005", id_instr); end
    checks++; if (id_pc_plus4 !== 32'h4 || id_valid !== 1'b1 || pc !== 32'h4) begin
      errors++; $display("FAIL seq_state pp4=%h valid=%b pc=%h exp 4/1/4", id_pc_plus4, id_valid, pc); end
  endtask

  task automatic test_branch();
    do_reset();
    repeat (4) tick();
    checks++; if (id_pc_plus4 !== 32'h10 || id_valid !== 1'b1) begin errors++; $display("FAIL br_setup pp4=%h valid=%b exp 10/1", id_pc_plus4, id_valid); end
    pc_src = 2'b01; branch_imm = 16'hFFFE;
    tick();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL br_target got=%h exp=8", pc); end
    checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin errors++; $display("FAIL br_bubble valid=%b instr=%h exp 0/0", id_valid, id_instr); end
    pc_src = 2'b00;
    tick();
    checks++; if (id_instr !== mem[2] || id_pc_plus4 !== 32'hC || id_valid !== 1'b1) begin
      errors++; $display("FAIL br_refetch instr=%h pp4=%h valid=%b exp %h/c/1", id_instr, id_pc_plus4, id_valid, mem[2]); end
  endtask

  task automatic test_jal_jr();
    do_reset();
    tick();
    pc_src = 2'b11; jr_target = 32'h2000_001C;
    tick();
    pc_src = 2'b00;
    tick();
    checks++; if (id_pc_plus4 !== 32'h2000_0020) begin errors++; $display("FAIL jal_setup got=%h exp=20000020", id_pc_plus4); end
    pc_src = 2'b10; jump_idx = 26'h40;
    tick();
    checks++; if (pc !== 32'h2000_0100) begin errors++; $display("FAIL jal_target got=%h exp=20000100", pc); end
    pc_src = 2'b00;
    tick();
    pc_src = 2'b11; jr_target = 32'h0000_003E;
    tick();
    checks++; if (pc !== 32'h3C) begin errors++; $display("FAIL jr_target got=%h exp=3c", pc); end
    pc_src = 2'b00;
  endtask

  task automatic test_stall_flush();
    logic [31:0] s_pc, s_i, s_p;
    do_reset();
    repeat (3) tick();
    s_pc = pc; s_i = id_instr; s_p = id_pc_plus4;
    stall = 1; pc_src = 2'b01; branch_imm = 16'h0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (pc !== s_pc || id_instr !== s_i || id_pc_plus4 !== s_p || id_valid !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d] pc=%h instr=%h pp4=%h valid=%b exp %h/%h/%h/1", k, pc, id_instr, id_pc_plus4, id_valid, s_pc, s_i, s_p); end
    end
    flush = 1;
    tick();
    checks++; if (id_valid !== 1'b0 || pc !== s_pc) begin errors++; $display("FAIL stall_flush valid=%b pc=%h exp 0/%h", id_valid, pc, s_pc); end
    idle_inputs();
  endtask

  task automatic test_wrap_bubble();
    do_reset();
    tick();
    pc_src = 2'b11; jr_target = 32'hFFFF_FFFC;
    tick();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got=%h exp=fffffffc", pc); end
    pc_src = 2'b10; jump_idx = 26'h155;
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=0", pc); end
    checks++; if (id_pc_plus4 !== 32'h0 || id_valid !== 1'b1) begin errors++; $display("FAIL wrap_pp4 got=%h valid=%b exp 0/1", id_pc_plus4, id_valid); end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      reset      = ($urandom_range(0, 49) == 0);
      stall      = ($urandom_range(0, 3) == 0);
      flush      = ($urandom_range(0, 9) == 0);
      pc_src     = 2'($urandom_range(0, 3));
      branch_imm = 16'($urandom);
      jump_idx   = 26'($urandom);
      jr_target  = $urandom;
      if ($urandom_range(0, 1) == 0) pc_src = 2'b00;
      tick();
      checks++; if (pc !== m_pc || id_instr !== m_instr || id_pc_plus4 !== m_pp4 || id_valid !== m_v) begin
        errors++; $display("FAIL rand[%0d] pc=%h instr=%h pp4=%h valid=%b exp %h/%h/%h/%b", k, pc, id_instr, id_pc_plus4, id_valid, m_pc, m_instr, m_pp4, m_v); end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0005;
    idle_inputs();
    test_reset();
    test_seq_fetch();
    test_branch();
    test_jal_jr();
    test_stall_flush();
    test_wrap_bubble();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the MIPS core: owns the program counter, drives the instruction-memory address, selects the next PC (sequential, branch, jump/jal, jr) and latches the fetched word into the IF/ID pipeline register consumed by decode. It sits directly upstream of the combinational instruction memory (word index = PC>>2) and directly upstream of the ID stage. Redirects are resolved in ID with no delay slot; the wrong-path word fetched during a redirect is squashed.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hold PC and IF/ID (load-use hazard)
- flush  in  1  force IF/ID to bubble at next edge
- pc_src  in  2  00 seq, 01 branch taken, 10 jump (j/jal), 11 jr
- branch_imm  in  16  branch offset field of instruction in ID
- jump_idx  in  26  jump index field of instruction in ID
- jr_target  in  32  register value for jr
- pc  out  32  current PC, to instruction memory address
- instr_in  in  32  word returned by instruction memory (combinational, same cycle)
- id_instr  out  32  IF/ID instruction
- id_pc_plus4  out  32  IF/ID PC+4 of id_instr
- id_valid  out  1  IF/ID holds a real instruction

## Operation
- pc_plus4 = pc + 32'd4, modulo 2^32 (wraps 0xFFFF_FFFC -> 0).
- Targets, computed from the IF/ID register (the redirecting instruction is in ID):
  - branch: id_pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00}, modulo 2^32
  - jump: {id_pc_plus4[31:28], jump_idx, 2'b00}
  - jr: {jr_target[31:2], 2'b00} (low bits forced to zero)
- Per-edge priority: reset > stall > redirect (pc_src != 00) > sequential.
  - reset: pc <= RESET_PC, id_instr <= 0, id_pc_plus4 <= 0, id_valid <= 0.
  - stall: pc held; pc_src ignored; IF/ID held, except flush, which still loads the bubble.
  - redirect: pc <= selected target; IF/ID <= bubble (id_instr 0, id_valid 0, id_pc_plus4 0).
  - sequential: pc <= pc_plus4; id_instr <= instr_in; id_pc_plus4 <= pc_plus4; id_valid <= 1.
- flush without stall: pc advances per pc_src; IF/ID loads bubble.
- Bubble encoding is 32'h0000_0000 (sll $0,$0,0) so decode needs no id_valid gating.
- pc_src is ignored while id_valid = 0; a bubble never redirects.

## Timing
- pc is a register; instr_in is valid combinationally within the same cycle.
- Fetch-to-ID latency is 1 edge: the word at pc in cycle n appears on id_instr in cycle n+1.
- Redirect penalty is 1 bubble: pc = target in the cycle after pc_src is sampled.
- The first cycle after reset deasserts presents pc = RESET_PC with id_valid = 0.
- Reset asserted mid-stall or mid-redirect takes effect at that edge and overrides everything.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package mips_pkg holds:
  - PCSRC_SEQ/BR/J/JR encodings
  - NOP_INSTR = 32'h0
  - the RESET_PC default
- Sub-module next_pc_mux: combinational target computation and 4-way select (sign-extend, shift, concat). if_stage holds the PC and IF/ID registers plus the priority logic.

## Test plan
- Reset: hold reset 2 cycles with stall=1, pc_src=10 -> pc=0, id_instr=0, id_valid=0. After release, pc runs 0, 4, 8.
- Sequential fetch: memory word 0 = 0x20080005 -> the next edge gives id_instr=0x20080005, id_pc_plus4=4, id_valid=1, pc=4.
- Backward branch: id_pc_plus4=0x10, branch_imm=0xFFFE, pc_src=01 -> pc=0x08, then id_valid=0 for one cycle. Refetch at 0x08 follows.
- jal and jr:
  - jal: id_pc_plus4=0x2000_0020, jump_idx=0x40 -> pc=0x2000_0100.
  - jr: jr_target=0x0000_003E -> pc=0x3C.
- Stall and flush:
  - stall=1 for 3 cycles with pc_src=01 -> pc, id_instr and id_pc_plus4 are unchanged and no redirect occurs.
  - stall=1 with flush=1 -> id_valid=0 and pc is held.
- Wrap and bubble: pc=0xFFFF_FFFC sequential -> pc=0, id_pc_plus4=0. With id_valid=0 and pc_src=10 -> pc advances sequentially.
